// File: rtl/ftdi_pkg.sv
// rtl/ftdi_pkg.sv - shared FTDI UART state encodings and baud tick constants
package ftdi_pkg;

  // FSM encoding shared by the FTDI receiver and transmitter
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_t;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS          = 8;

  // round(oversample * baud * 2^acc_width / clk_freq); wide math keeps the product exact
  function automatic logic [63:0] tick_inc(input longint unsigned clk_freq,
                                           input longint unsigned baud,
                                           input longint unsigned oversample,
                                           input int unsigned     acc_width);
    logic [127:0] num;
    logic [127:0] quo;
    num = (128'(oversample) * 128'(baud)) << acc_width;
    quo = (num + 128'(clk_freq / 2)) / 128'(clk_freq);
    tick_inc = quo[63:0];
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - fractional accumulator producing the oversample tick
module uart_tick_gen
  import ftdi_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // the increment is one bit wider than the accumulator so a tick every clock is representable
  localparam logic [63:0]        TICK_INC_FULL = tick_inc(CLK_FREQ, BAUD_RATE, OVERSAMPLE, ACC_WIDTH);
  localparam logic [ACC_WIDTH:0] TICK_INC      = TICK_INC_FULL[ACC_WIDTH:0];

  logic [ACC_WIDTH:0] acc;

  // free-running accumulator; the carry bit is the tick and is dropped on the next add
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= {1'b0, acc[ACC_WIDTH-1:0]} + TICK_INC;
    end
  end

  assign tick = acc[ACC_WIDTH];

endmodule

// File: rtl/ftdi_uart_rx.sv
// rtl/ftdi_uart_rx.sv - 8N1 UART receiver for the FTDI link with majority vote
module ftdi_uart_rx
  import ftdi_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_PRE  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_VOTE = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic        tick;
  logic        rx_meta;
  logic        rxs;
  uart_state_t state;
  logic [SW-1:0] s_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        v0;
  logic        v1;
  logic        vote;

  uart_tick_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // two-flop synchronizer on the asynchronous pin; resets to the idle-high level
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  // 2-of-3 vote: the two earlier samples plus the line value on the vote tick itself
  assign vote = (v0 & v1) | (v0 & rxs) | (v1 & rxs);

  assign state_dbg = state;

  // receive FSM with sample counter, vote capture and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      s_cnt     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      v0        <= 1'b1;
      v1        <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      // sample counter only runs while a frame is being timed
      if (tick && (state == ST_START || state == ST_DATA || state == ST_STOP)) begin
        s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
        if (s_cnt == S_PRE) v0 <= rxs;
        if (s_cnt == S_MID) v1 <= rxs;
      end

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            s_cnt <= '0;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (s_cnt == S_VOTE && vote) begin
              // start bit did not hold low through mid-bit: treat as a glitch
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (s_cnt == S_LAST) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (s_cnt == S_VOTE) begin
              shift <= {vote, shift[7:1]};
            end
            if (s_cnt == S_LAST) begin
              if (bit_cnt == LAST_BIT) begin
                state <= ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        ST_STOP: begin
          if (tick && s_cnt == S_VOTE) begin
            if (vote) begin
              if (!rx_valid || rx_ack) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              // leave at mid-stop so a back-to-back start bit is not missed
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          // hold off re-triggering while the line sits in a break
          if (rxs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
